nios2_dbg_scan_engine: RTL and testbench

Single-clock, parametrised successor to the Nios II debug-slave scan path. It holds the JTAG data-register shift chain, selects capture data per instruction, commits shifted frames to `jdo`, and issues one action per update to the CPU debug logic over a valid/ready handshake. It adds three things to the fixed-width design: parametrised data width, parametrised breakpoint count, and an overrun flag for updates that arrive while an action is still pending. It sits between the already-synchronised virtual-JTAG strobes and the OCI memory, trace and break blocks in the `clk` domain.

---
 rtl/nios2_dbg_pkg.sv | 19 +
 rtl/nios2_dbg_capture_mux.sv | 48 ++++
 rtl/nios2_dbg_scan_engine.sv | 134 +++++++++++++
 tb/tb_nios2_dbg_scan_engine.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_dbg_pkg.sv
// Shared constants, FSM state type and width helper for the Nios II debug scan engine.
package nios2_dbg_pkg;

    localparam logic [31:0] IR_OCIMEM = 32'd0;
    localparam logic [31:0] IR_TRACE  = 32'd1;
    localparam logic [31:0] IR_BREAK  = 32'd2;
    localparam logic [31:0] IR_STATUS = 32'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFTING = 2'd1,
        ST_PENDING  = 2'd2
    } state_t;

    function automatic int sr_w(input int data_w);
        return data_w + 6;
    endfunction

endpackage

// File: rtl/nios2_dbg_capture_mux.sv
// Combinational selection of the capture word loaded into the scan chain, by instruction.
// Trace capture is present only when NIOS2_DBG_TRACE_EN is defined.
module nios2_dbg_capture_mux
    import nios2_dbg_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int IR_W    = 2,
    parameter int NUM_BRK = 4
) (
    input  logic [IR_W-1:0]         i_ir,
    input  logic                    i_overrun,
    input  logic                    i_debugack,
    input  logic                    i_mon_error,
    input  logic                    i_mon_ready,
    input  logic                    i_resetlatch,
    input  logic [DATA_W-1:0]       i_mon_data,
    input  logic [DATA_W-1:0]       i_break_readreg,
    input  logic [NUM_BRK-1:0]      i_brk_hit,
    input  logic [DATA_W+3:0]       i_trc_data,
    output logic [sr_w(DATA_W)-1:0] o_word
);

    logic [31:0]       w_ir32;
    logic [DATA_W-1:0] w_brk_ext;

    assign w_ir32    = 32'(i_ir);
    assign w_brk_ext = DATA_W'(i_brk_hit);

`ifndef NIOS2_DBG_TRACE_EN
    logic w_unused_trc;
    assign w_unused_trc = ^i_trc_data;
`endif

    always_comb begin
        o_word = '0;
        case (w_ir32)
            IR_OCIMEM: o_word = {i_overrun, i_debugack, i_mon_error, i_mon_ready,
                                 i_resetlatch, 1'b0, i_mon_data};
`ifdef NIOS2_DBG_TRACE_EN
            IR_TRACE:  o_word = {2'b00, i_trc_data};
`endif
            IR_BREAK:  o_word = {i_overrun, 5'b00000, i_break_readreg};
            IR_STATUS: o_word = {i_overrun, i_debugack, i_resetlatch, 3'b000, w_brk_ext};
            default:   o_word = '0;
        endcase
    end

endmodule

// File: rtl/nios2_dbg_scan_engine.sv
// JTAG data-register scan chain, jdo commit and valid/ready action issue for the Nios II debug slave.
// Optional trace instruction support is enabled by defining NIOS2_DBG_TRACE_EN.
module nios2_dbg_scan_engine
    import nios2_dbg_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int IR_W    = 2,
    parameter int NUM_BRK = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [IR_W-1:0]         ir_in,
    input  logic                    scan_capture,
    input  logic                    scan_shift,
    input  logic                    scan_tdi,
    input  logic                    scan_update,
    output logic                    scan_tdo,
    input  logic [DATA_W-1:0]       mon_data,
    input  logic                    mon_ready,
    input  logic                    mon_error,
    input  logic                    debugack,
    input  logic                    resetlatch,
    input  logic [NUM_BRK-1:0]      brk_hit,
    input  logic [DATA_W-1:0]       break_readreg,
    input  logic [DATA_W+3:0]       trc_data,
    output logic [sr_w(DATA_W)-1:0] jdo,
    output logic                    act_valid,
    output logic [IR_W-1:0]         act_ir,
    output logic                    act_take,
    output logic                    act_sub,
    input  logic                    act_ready,
    output logic                    overrun
);

    localparam int SR_W = sr_w(DATA_W);

    state_t          r_state;
    logic [SR_W-1:0] r_sr;
    logic [SR_W-1:0] r_jdo;
    logic            r_act_valid;
    logic [IR_W-1:0] r_act_ir;
    logic            r_act_take;
    logic            r_act_sub;
    logic            r_overrun;

    logic [SR_W-1:0] w_cap_word;
    logic [31:0]     w_ir32;
    logic            w_ir_act;
    logic            w_acc;

    nios2_dbg_capture_mux #(
        .DATA_W  (DATA_W),
        .IR_W    (IR_W),
        .NUM_BRK (NUM_BRK)
    ) u_capture_mux (
        .i_ir            (ir_in),
        .i_overrun       (r_overrun),
        .i_debugack      (debugack),
        .i_mon_error     (mon_error),
        .i_mon_ready     (mon_ready),
        .i_resetlatch    (resetlatch),
        .i_mon_data      (mon_data),
        .i_break_readreg (break_readreg),
        .i_brk_hit       (brk_hit),
        .i_trc_data      (trc_data),
        .o_word          (w_cap_word)
    );

    assign w_ir32 = 32'(ir_in);
    assign w_acc  = r_act_valid && act_ready;

    // Instructions that can raise an action; everything else only commits jdo.
`ifdef NIOS2_DBG_TRACE_EN
    assign w_ir_act = (w_ir32 <= IR_STATUS);
`else
    assign w_ir_act = (w_ir32 == IR_OCIMEM) || (w_ir32 == IR_BREAK) || (w_ir32 == IR_STATUS);
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_sr        <= '0;
            r_jdo       <= '0;
            r_act_valid <= 1'b0;
            r_act_ir    <= '0;
            r_act_take  <= 1'b0;
            r_act_sub   <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_acc) begin
                r_act_valid <= 1'b0;
            end
            if (scan_capture) begin
                r_sr <= w_cap_word;
                if (w_ir32 == IR_STATUS) begin
                    r_overrun <= 1'b0;
                end
                if (r_state != ST_PENDING || w_acc) begin
                    r_state <= ST_SHIFTING;
                end
            end else if (scan_update) begin
                r_jdo <= r_sr;
                // An update landing on the accepting edge starts a fresh action, not an overrun.
                if (w_ir_act && r_act_valid && !w_acc) begin
                    r_overrun <= 1'b1;
                end else if (w_ir_act) begin
                    r_act_valid <= 1'b1;
                    r_act_ir    <= ir_in;
                    r_act_take  <= r_sr[SR_W-1];
                    r_act_sub   <= r_sr[SR_W-2];
                    r_state     <= ST_PENDING;
                end else if (r_state != ST_PENDING || w_acc) begin
                    r_state <= ST_IDLE;
                end
            end else begin
                if (scan_shift) begin
                    r_sr <= {scan_tdi, r_sr[SR_W-1:1]};
                end
                if (w_acc) begin
                    r_state <= ST_IDLE;
                end
            end
        end
    end

    assign scan_tdo  = r_sr[0];
    assign jdo       = r_jdo;
    assign act_valid = r_act_valid;
    assign act_ir    = r_act_ir;
    assign act_take  = r_act_take;
    assign act_sub   = r_act_sub;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_nios2_dbg_scan_engine.sv
// Directed plus randomized bench for nios2_dbg_scan_engine against a behavioural frame model.
module tb_nios2_dbg_scan_engine;

    localparam int DATA_W  = 32;
    localparam int IR_W    = 3;
    localparam int NUM_BRK = 4;
    localparam int SR_W    = DATA_W + 6;
`ifdef NIOS2_DBG_TRACE_EN
    localparam bit TRACE = 1'b1;
`else
    localparam bit TRACE = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic [IR_W-1:0]   ir_in;
    logic              scan_capture, scan_shift, scan_tdi, scan_update;
    logic              scan_tdo;
    logic [DATA_W-1:0] mon_data, break_readreg;
    logic              mon_ready, mon_error, debugack, resetlatch;
    logic [NUM_BRK-1:0] brk_hit;
    logic [DATA_W+3:0] trc_data;
    logic [SR_W-1:0]   jdo;
    logic              act_valid, act_take, act_sub, act_ready, overrun;
    logic [IR_W-1:0]   act_ir;

    nios2_dbg_scan_engine #(.DATA_W(DATA_W), .IR_W(IR_W), .NUM_BRK(NUM_BRK)) dut (
        .clk(clk), .reset_n(reset_n), .ir_in(ir_in),
        .scan_capture(scan_capture), .scan_shift(scan_shift), .scan_tdi(scan_tdi),
        .scan_update(scan_update), .scan_tdo(scan_tdo),
        .mon_data(mon_data), .mon_ready(mon_ready), .mon_error(mon_error),
        .debugack(debugack), .resetlatch(resetlatch), .brk_hit(brk_hit),
        .break_readreg(break_readreg), .trc_data(trc_data),
        .jdo(jdo), .act_valid(act_valid), .act_ir(act_ir), .act_take(act_take),
        .act_sub(act_sub), .act_ready(act_ready), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: the frame being shifted, last committed frame, and the pending action.
    logic [SR_W-1:0] m_sr, m_jdo;
    logic            m_valid, m_take, m_sub, m_ovr;
    logic [IR_W-1:0] m_ir;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [SR_W-1:0] cap_word();
        int unsigned code = 32'(ir_in);
        if (code == 0) return {m_ovr, debugack, mon_error, mon_ready, resetlatch, 1'b0, mon_data};
        if (code == 1) return TRACE ? {2'b00, trc_data} : '0;
        if (code == 2) return {m_ovr, 5'b0, break_readreg};
        if (code == 3) return {m_ovr, debugack, resetlatch, 3'b0, 28'b0, brk_hit};
        return '0;
    endfunction

    task automatic model_step();
        logic [SR_W-1:0] n_sr, n_jdo;
        logic            n_valid, n_take, n_sub, n_ovr, acc, can_act;
        logic [IR_W-1:0] n_ir;
        int unsigned     code = 32'(ir_in);
        if (!reset_n) begin
            m_sr = '0; m_jdo = '0; m_valid = 0; m_ir = '0; m_take = 0; m_sub = 0; m_ovr = 0;
            return;
        end
        n_sr = m_sr; n_jdo = m_jdo; n_valid = m_valid; n_ir = m_ir;
        n_take = m_take; n_sub = m_sub; n_ovr = m_ovr;
        acc = m_valid && act_ready;
        can_act = (code == 0) || (code == 2) || (code == 3) || (TRACE && code == 1);
        if (acc) n_valid = 0;
        if (scan_capture) begin
            n_sr = cap_word();
            if (code == 3) n_ovr = 0;
        end else if (scan_update) begin
            n_jdo = m_sr;
            if (can_act) begin
                if (m_valid && !acc) n_ovr = 1;
                else begin
                    n_valid = 1; n_ir = ir_in; n_take = m_sr[SR_W-1]; n_sub = m_sr[SR_W-2];
                end
            end
        end else if (scan_shift) begin
            n_sr = (m_sr >> 1) | ({{(SR_W-1){1'b0}}, scan_tdi} << (SR_W-1));
        end
        m_sr = n_sr; m_jdo = n_jdo; m_valid = n_valid; m_ir = n_ir;
        m_take = n_take; m_sub = n_sub; m_ovr = n_ovr;
    endtask

    task automatic check_all();
        chk("jdo", 64'(jdo), 64'(m_jdo));
        chk("act_valid", 64'(act_valid), 64'(m_valid));
        chk("act_ir", 64'(act_ir), 64'(m_ir));
        chk("act_take", 64'(act_take), 64'(m_take));
        chk("act_sub", 64'(act_sub), 64'(m_sub));
        chk("overrun", 64'(overrun), 64'(m_ovr));
        chk("scan_tdo", 64'(scan_tdo), 64'(m_sr[0]));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        scan_capture = 0; scan_shift = 0; scan_update = 0;
        check_all();
    endtask

    initial begin
        logic [SR_W-1:0] exp_word, frame;
        logic [IR_W-1:0] hold_ir;
        reset_n = 0; ir_in = '0; scan_capture = 0; scan_shift = 0; scan_tdi = 0; scan_update = 0;
        mon_data = '0; break_readreg = '0; mon_ready = 0; mon_error = 0; debugack = 0;
        resetlatch = 0; brk_hit = '0; trc_data = '0; act_ready = 0;
        m_sr = '0; m_jdo = '0; m_valid = 0; m_ir = '0; m_take = 0; m_sub = 0; m_ovr = 0;

        tick();
        chk("reset_jdo", 64'(jdo), 64'd0);
        chk("reset_valid", 64'(act_valid), 64'd0);
        reset_n = 1;

        // OCIMEM capture then stream the full frame out
        ir_in = 3'd0; mon_data = 32'hDEADBEEF; mon_ready = 1;
        exp_word = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
        scan_capture = 1; tick();
        for (int i = 0; i < SR_W; i++) begin
            chk($sformatf("stream_bit%0d", i), 64'(scan_tdo), 64'(exp_word[i]));
            scan_tdi = 1'($urandom); scan_shift = 1; tick();
        end

        // BREAK frame with take=1, sub=0
        ir_in = 3'd2; break_readreg = $urandom;
        scan_capture = 1; tick();
        frame = {2'b10, 4'($urandom), 32'($urandom)};
        for (int i = 0; i < SR_W; i++) begin
            scan_tdi = frame[i]; scan_shift = 1; tick();
        end
        scan_update = 1; tick();
        chk("brk_valid", 64'(act_valid), 64'd1);
        chk("brk_ir", 64'(act_ir), 64'd2);
        chk("brk_take", 64'(act_take), 64'd1);
        chk("brk_sub", 64'(act_sub), 64'd0);
        chk("brk_jdo", 64'(jdo), 64'(frame));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_ir", 64'(act_ir), 64'd2);
            chk("hold_take", 64'(act_take), 64'd1);
        end

        // Second update while pending raises overrun; STATUS capture reports then clears it
        ir_in = 3'd0; scan_update = 1; tick();
        chk("ovr_set", 64'(overrun), 64'd1);
        chk("ovr_keep_ir", 64'(act_ir), 64'd2);
        ir_in = 3'd3; scan_capture = 1; tick();
        chk("ovr_clear", 64'(overrun), 64'd0);
        scan_tdi = 0;
        for (int i = 0; i < SR_W - 1; i++) begin
            scan_shift = 1; tick();
        end
        chk("status_bit37", 64'(scan_tdo), 64'd1);

        // Capture wins over a coincident shift
        ir_in = 3'd0; mon_data = 32'h0000_0001; scan_tdi = 0;
        scan_capture = 1; scan_shift = 1; tick();
        chk("cap_over_shift", 64'(scan_tdo), 64'd1);

        // Update on the accepting edge starts a new action without overrun
        act_ready = 1; scan_update = 1; tick();
        act_ready = 0;
        chk("acc_upd_valid", 64'(act_valid), 64'd1);
        chk("acc_upd_ir", 64'(act_ir), 64'd0);
        chk("acc_upd_ovr", 64'(overrun), 64'd0);
        act_ready = 1; tick(); act_ready = 0;
        chk("drained", 64'(act_valid), 64'd0);

        // TRACE instruction
        ir_in = 3'd1; trc_data = '1; scan_capture = 1; tick();
        scan_update = 1; tick();
`ifndef NIOS2_DBG_TRACE_EN
        chk("trace_off_jdo", 64'(jdo), 64'd0);
        chk("trace_off_valid", 64'(act_valid), 64'd0);
`endif
        act_ready = 1; tick(); act_ready = 0;

        // IR >= 4 never raises an action
        ir_in = 3'd5; scan_update = 1; tick();
        chk("ir5_valid", 64'(act_valid), 64'd0);

        // Reset while pending drops the action
        ir_in = 3'd2; scan_update = 1; tick();
        chk("pend_before_rst", 64'(act_valid), 64'd1);
        reset_n = 0; tick(); reset_n = 1;
        chk("rst_drop", 64'(act_valid), 64'd0);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            hold_ir = 3'($urandom_range(0, 7));
            ir_in = hold_ir;
            scan_capture = ($urandom_range(0, 7) == 0);
            scan_update = ($urandom_range(0, 5) == 0);
            scan_shift = ($urandom_range(0, 1) == 0);
            scan_tdi = 1'($urandom);
            act_ready = ($urandom_range(0, 3) == 0);
            mon_data = $urandom; break_readreg = $urandom;
            trc_data = {4'($urandom), 32'($urandom)};
            brk_hit = 4'($urandom);
            {mon_ready, mon_error, debugack, resetlatch} = 4'($urandom);
            reset_n = ($urandom_range(0, 299) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
